mem_ctrl: RTL and testbench



---
 rtl/mem_ctrl_if.sv | 69 ++++++
 rtl/mem_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: client and RAM bus bundle for the memory controller.
//
// Request/done semantics: every in_*_flag is a one-cycle request pulse with
// its fields valid in the same cycle; the matching out_*_flag is a one-cycle
// completion pulse, and out_*_data stays valid until the next completion.
// A client never issues a new request before its previous done pulse.
// There is no backpressure towards the clients; the controller queues one
// request per client internally.
//
// Signals
//   in_rob_xbp                      misprediction flush
//   in_fetcher_* / out_fetcher_*    instruction fetch (always 4 bytes)
//   in_lsb_* / out_lsb_*            loads (1/2/4 bytes, signed or unsigned)
//   in_rob_* / out_rob_flag         committed stores (1/2/4 bytes)
//   mem_din, mem_dout, mem_a, mem_wr   byte-wide synchronous RAM port
//   io_buffer_full                  UART output buffer full
//
// Modports: slave = controller side, master = clients + RAM side.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              in_rob_xbp;
  logic              in_fetcher_flag;
  logic [ADDR_W-1:0] in_fetcher_addr;
  logic              out_fetcher_flag;
  logic [ADDR_W-1:0] out_fetcher_data;
  logic              in_lsb_flag;
  logic [5:0]        in_lsb_size;
  logic              in_lsb_signed;
  logic [ADDR_W-1:0] in_lsb_addr;
  logic              out_lsb_flag;
  logic [ADDR_W-1:0] out_lsb_data;
  logic              in_rob_flag;
  logic [5:0]        in_rob_size;
  logic [ADDR_W-1:0] in_rob_addr;
  logic [ADDR_W-1:0] in_rob_data;
  logic              out_rob_flag;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic              io_buffer_full;

  modport slave (
    input  in_rob_xbp,
    input  in_fetcher_flag, in_fetcher_addr,
    output out_fetcher_flag, out_fetcher_data,
    input  in_lsb_flag, in_lsb_size, in_lsb_signed, in_lsb_addr,
    output out_lsb_flag, out_lsb_data,
    input  in_rob_flag, in_rob_size, in_rob_addr, in_rob_data,
    output out_rob_flag,
    input  mem_din,
    output mem_dout, mem_a, mem_wr,
    input  io_buffer_full
  );

  modport master (
    output in_rob_xbp,
    output in_fetcher_flag, in_fetcher_addr,
    input  out_fetcher_flag, out_fetcher_data,
    output in_lsb_flag, in_lsb_size, in_lsb_signed, in_lsb_addr,
    input  out_lsb_flag, out_lsb_data,
    output in_rob_flag, in_rob_size, in_rob_addr, in_rob_data,
    input  out_rob_flag,
    output mem_din,
    input  mem_dout, mem_a, mem_wr,
    output io_buffer_full
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises instruction fetch, loads and committed stores onto a
// single-port byte-wide synchronous RAM.
//
// Ports
//   clk        clock
//   rst        asynchronous active-high reset
//   rdy        global enable; low freezes all state and forces mem_wr to 0
//   bus        mem_ctrl_if.slave (client requests/dones, RAM port, UART full)
//   dbg_state  current FSM state (0 IDLE, 1 READ, 2 WRITE)
//
// Each client has one pending slot. In IDLE the controller grants
// store > load > fetch, looking at the slots merged with same-cycle request
// pulses so a request can be granted on the edge it arrives.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  mem_ctrl_if.slave  bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] IO_ADDR_0 = ADDR_W'(32'h0003_0000);
  localparam logic [ADDR_W-1:0] IO_ADDR_1 = ADDR_W'(32'h0003_0004);

  state_t            state;
  logic [2:0]        cnt;

  // pending slots
  logic              f_v;
  logic [ADDR_W-1:0] f_addr;
  logic              l_v;
  logic [5:0]        l_size;
  logic              l_signed;
  logic [ADDR_W-1:0] l_addr;
  logic              s_v;
  logic [5:0]        s_size;
  logic [ADDR_W-1:0] s_addr;
  logic [ADDR_W-1:0] s_data;

  // active transaction
  logic              a_is_fetch;
  logic              a_signed;
  logic [2:0]        a_len;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] a_data;
  logic [ADDR_W-1:0] rd_buf;

  // registered outputs
  logic              f_done;
  logic [ADDR_W-1:0] f_data_q;
  logic              l_done;
  logic [ADDR_W-1:0] l_data_q;
  logic              s_done;
  logic [ADDR_W-1:0] mem_a_q;
  logic [7:0]        mem_dout_q;
  logic              wr_q;

  logic              f_pend, l_pend, s_pend;
  logic [ADDR_W-1:0] f_addr_e, l_addr_e, s_addr_e, s_data_e;
  logic [5:0]        l_size_e, s_size_e;
  logic              l_signed_e;
  logic              g_f, g_l, g_s;
  logic [1:0]        cap_idx;
  logic [ADDR_W-1:0] rd_next;
  logic [ADDR_W-1:0] ld_ext;
  logic [ADDR_W-1:0] cur_addr;
  logic              io_stall;

  // Slots merged with this cycle's pulses. A flush kills fetch/load requests,
  // including one arriving in the same cycle; stores are already committed.
  always_comb begin
    f_pend     = (f_v | bus.in_fetcher_flag) & ~bus.in_rob_xbp;
    l_pend     = (l_v | bus.in_lsb_flag) & ~bus.in_rob_xbp;
    s_pend     = s_v | bus.in_rob_flag;
    f_addr_e   = bus.in_fetcher_flag ? bus.in_fetcher_addr : f_addr;
    l_addr_e   = bus.in_lsb_flag ? bus.in_lsb_addr : l_addr;
    l_size_e   = bus.in_lsb_flag ? bus.in_lsb_size : l_size;
    l_signed_e = bus.in_lsb_flag ? bus.in_lsb_signed : l_signed;
    s_addr_e   = bus.in_rob_flag ? bus.in_rob_addr : s_addr;
    s_size_e   = bus.in_rob_flag ? bus.in_rob_size : s_size;
    s_data_e   = bus.in_rob_flag ? bus.in_rob_data : s_data;
    g_s        = (state == IDLE) && s_pend;
    g_l        = (state == IDLE) && !s_pend && l_pend;
    g_f        = (state == IDLE) && !s_pend && !l_pend && f_pend;
  end

  // In READ, cnt = k issues address k (k < N); the RAM returns that byte one
  // cycle later, so it is captured when cnt = k + 2. The last capture happens
  // at cnt = N + 1, together with the done pulse.
  always_comb begin
    cap_idx = 2'(cnt - 3'd2);
    rd_next = rd_buf;
    if (cnt >= 3'd2) rd_next[{cap_idx, 3'b000} +: 8] = bus.mem_din;
    ld_ext = rd_next;
    if (a_len == 3'd1) begin
      ld_ext = a_signed ? {{(ADDR_W-8){rd_next[7]}}, rd_next[7:0]}
                        : {{(ADDR_W-8){1'b0}}, rd_next[7:0]};
    end else if (a_len == 3'd2) begin
      ld_ext = a_signed ? {{(ADDR_W-16){rd_next[15]}}, rd_next[15:0]}
                        : {{(ADDR_W-16){1'b0}}, rd_next[15:0]};
    end
    cur_addr = a_addr + ADDR_W'(cnt);   // wraps modulo 2^ADDR_W
    io_stall = ((a_addr == IO_ADDR_0) || (a_addr == IO_ADDR_1)) && bus.io_buffer_full;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      f_v        <= 1'b0;
      f_addr     <= '0;
      l_v        <= 1'b0;
      l_size     <= '0;
      l_signed   <= 1'b0;
      l_addr     <= '0;
      s_v        <= 1'b0;
      s_size     <= '0;
      s_addr     <= '0;
      s_data     <= '0;
      a_is_fetch <= 1'b0;
      a_signed   <= 1'b0;
      a_len      <= '0;
      a_addr     <= '0;
      a_data     <= '0;
      rd_buf     <= '0;
      f_done     <= 1'b0;
      f_data_q   <= '0;
      l_done     <= 1'b0;
      l_data_q   <= '0;
      s_done     <= 1'b0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      wr_q       <= 1'b0;
    end else if (rdy) begin
      f_done <= 1'b0;
      l_done <= 1'b0;
      s_done <= 1'b0;

      if (bus.in_fetcher_flag) f_addr <= bus.in_fetcher_addr;
      if (bus.in_lsb_flag) begin
        l_addr   <= bus.in_lsb_addr;
        l_size   <= bus.in_lsb_size;
        l_signed <= bus.in_lsb_signed;
      end
      if (bus.in_rob_flag) begin
        s_addr <= bus.in_rob_addr;
        s_size <= bus.in_rob_size;
        s_data <= bus.in_rob_data;
      end
      f_v <= f_pend & ~g_f;
      l_v <= l_pend & ~g_l;
      s_v <= s_pend & ~g_s;

      case (state)
        IDLE: begin
          wr_q <= 1'b0;
          cnt  <= '0;
          if (g_s) begin
            state  <= WRITE;
            a_addr <= s_addr_e;
            a_len  <= s_size_e[2:0];
            a_data <= s_data_e;
          end else if (g_l) begin
            state      <= READ;
            a_is_fetch <= 1'b0;
            a_addr     <= l_addr_e;
            a_len      <= l_size_e[2:0];
            a_signed   <= l_signed_e;
            rd_buf     <= '0;
          end else if (g_f) begin
            state      <= READ;
            a_is_fetch <= 1'b1;
            a_addr     <= f_addr_e;
            a_len      <= 3'd4;
            a_signed   <= 1'b0;
            rd_buf     <= '0;
          end
        end

        READ: begin
          if (bus.in_rob_xbp) begin
            state <= IDLE;   // abort silently, no done pulse
          end else begin
            if (cnt < a_len) mem_a_q <= cur_addr;
            rd_buf <= rd_next;
            cnt    <= cnt + 3'd1;
            if (cnt == a_len + 3'd1) begin
              state <= IDLE;
              if (a_is_fetch) begin
                f_done   <= 1'b1;
                f_data_q <= rd_next;
              end else begin
                l_done   <= 1'b1;
                l_data_q <= ld_ext;
              end
            end
          end
        end

        WRITE: begin
          if (cnt == a_len) begin
            wr_q   <= 1'b0;
            s_done <= 1'b1;
            state  <= IDLE;
          end else if (io_stall) begin
            wr_q <= 1'b0;    // hold k until the UART buffer drains
          end else begin
            mem_a_q    <= cur_addr;
            mem_dout_q <= a_data[{cnt[1:0], 3'b000} +: 8];
            wr_q       <= 1'b1;
            cnt        <= cnt + 3'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_fetcher_flag = f_done;
  assign bus.out_fetcher_data = f_data_q;
  assign bus.out_lsb_flag     = l_done;
  assign bus.out_lsb_data     = l_data_q;
  assign bus.out_rob_flag     = s_done;
  assign bus.mem_a            = mem_a_q;
  assign bus.mem_dout         = mem_dout_q;
  assign bus.mem_wr           = wr_q & rdy;
  assign dbg_state            = state;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;
  logic       clk;
  logic       rst;
  logic       rdy;
  logic [1:0] dbg_state;

  mem_ctrl_if #(.ADDR_W(32)) bus ();

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- RAM model (synchronous read, byte wide) ----------------
  logic [7:0] ram [0:65535];

  always @(posedge clk) begin
    if (bus.mem_wr) ram[bus.mem_a[15:0]] <= bus.mem_dout;
    bus.mem_din <= ram[bus.mem_a[15:0]];
  end

  // ---------------- scoreboard ----------------
  int          checks;
  int          errors;
  logic [31:0] exp_f_q[$];
  logic [31:0] exp_l_q[$];
  logic [31:0] exp_r_q[$];
  logic [63:0] exp_w_q[$];
  int          order_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_fetcher_flag) begin
        order_q.push_back(0);
        check("fetch_pending", 64'(exp_f_q.size() != 0), 64'd1);
        if (exp_f_q.size() != 0) check("fetch_data", 64'(bus.out_fetcher_data), 64'(exp_f_q.pop_front()));
      end
      if (bus.out_lsb_flag) begin
        order_q.push_back(1);
        check("lsb_pending", 64'(exp_l_q.size() != 0), 64'd1);
        if (exp_l_q.size() != 0) check("lsb_data", 64'(bus.out_lsb_data), 64'(exp_l_q.pop_front()));
      end
      if (bus.out_rob_flag) begin
        order_q.push_back(2);
        check("rob_pending", 64'(exp_r_q.size() != 0), 64'd1);
        if (exp_r_q.size() != 0) void'(exp_r_q.pop_front());
      end
      if (bus.mem_wr) begin
        check("write_pending", 64'(exp_w_q.size() != 0), 64'd1);
        if (exp_w_q.size() != 0)
          check("write_byte", {24'b0, bus.mem_a, bus.mem_dout}, exp_w_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fetch_req(input logic [31:0] addr, input logic [31:0] exp, input bit expect_done);
    if (expect_done) exp_f_q.push_back(exp);
    bus.in_fetcher_flag = 1'b1;
    bus.in_fetcher_addr = addr;
  endtask

  task automatic load_req(input logic [31:0] addr, input int size, input bit sgn,
                          input logic [31:0] exp, input bit expect_done);
    if (expect_done) exp_l_q.push_back(exp);
    bus.in_lsb_flag   = 1'b1;
    bus.in_lsb_addr   = addr;
    bus.in_lsb_size   = 6'(size);
    bus.in_lsb_signed = sgn;
  endtask

  task automatic store_req(input logic [31:0] addr, input int size, input logic [31:0] data);
    exp_r_q.push_back(addr);
    for (int i = 0; i < size; i++)
      exp_w_q.push_back({24'b0, addr + 32'(i), data[8*i +: 8]});
    bus.in_rob_flag = 1'b1;
    bus.in_rob_addr = addr;
    bus.in_rob_size = 6'(size);
    bus.in_rob_data = data;
  endtask

  // Request fields are sampled at the next edge (E0); returns just after it.
  task automatic issue();
    @(posedge clk);
    @(negedge clk);
    bus.in_fetcher_flag = 1'b0;
    bus.in_lsb_flag     = 1'b0;
    bus.in_rob_flag     = 1'b0;
  endtask

  task automatic wait_done(input int sel, input int max_cyc, output int cyc);
    logic seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < max_cyc) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      case (sel)
        0:       seen = bus.out_fetcher_flag;
        1:       seen = bus.out_lsb_flag;
        default: seen = bus.out_rob_flag;
      endcase
    end
  endtask

  // ---------------- directed sequence ----------------
  int cyc;
  int exp_order [3];

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    rdy = 1'b1;
    bus.in_rob_xbp      = 1'b0;
    bus.in_fetcher_flag = 1'b0;
    bus.in_fetcher_addr = '0;
    bus.in_lsb_flag     = 1'b0;
    bus.in_lsb_size     = '0;
    bus.in_lsb_signed   = 1'b0;
    bus.in_lsb_addr     = '0;
    bus.in_rob_flag     = 1'b0;
    bus.in_rob_size     = '0;
    bus.in_rob_addr     = '0;
    bus.in_rob_data     = '0;
    bus.io_buffer_full  = 1'b0;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0010] = 8'h13; ram[16'h0011] = 8'h05; ram[16'h0012] = 8'h10; ram[16'h0013] = 8'h00;
    ram[16'h0040] = 8'h80;
    ram[16'h0050] = 8'hFE; ram[16'h0051] = 8'hFF;
    ram[16'h0060] = 8'h44; ram[16'h0061] = 8'h33; ram[16'h0062] = 8'h22; ram[16'h0063] = 8'h11;
    ram[16'h0070] = 8'hBE; ram[16'h0071] = 8'hBA; ram[16'h0072] = 8'hFE; ram[16'h0073] = 8'hCA;
    ram[16'h0080] = 8'h01; ram[16'h0081] = 8'h02; ram[16'h0082] = 8'h03; ram[16'h0083] = 8'h04;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_fetch_flag", 64'(bus.out_fetcher_flag), 64'd0);
    check("reset_lsb_flag",   64'(bus.out_lsb_flag),     64'd0);
    check("reset_rob_flag",   64'(bus.out_rob_flag),     64'd0);
    check("reset_fetch_data", 64'(bus.out_fetcher_data), 64'd0);
    check("reset_lsb_data",   64'(bus.out_lsb_data),     64'd0);
    check("reset_mem_a",      64'(bus.mem_a),            64'd0);
    check("reset_mem_dout",   64'(bus.mem_dout),         64'd0);
    check("reset_mem_wr",     64'(bus.mem_wr),           64'd0);
    check("reset_state",      64'(dbg_state),            64'd0);
    rst = 1'b0;
    @(negedge clk);

    // instruction fetch, 6-cycle latency, data held afterwards
    fetch_req(32'h0000_0010, 32'h0010_0513, 1'b1);
    issue();
    wait_done(0, 20, cyc);
    check("fetch_latency", 64'(cyc), 64'd6);
    @(negedge clk);
    check("fetch_flag_one_cycle", 64'(bus.out_fetcher_flag), 64'd0);
    check("fetch_data_held", 64'(bus.out_fetcher_data), 64'h0010_0513);

    // loads: LB signed, LHU, LH signed, LW
    load_req(32'h0000_0040, 1, 1'b1, 32'hFFFF_FF80, 1'b1);
    issue();
    wait_done(1, 20, cyc);
    check("lb_latency", 64'(cyc), 64'd3);
    load_req(32'h0000_0050, 2, 1'b0, 32'h0000_FFFE, 1'b1);
    issue();
    wait_done(1, 20, cyc);
    check("lhu_latency", 64'(cyc), 64'd4);
    load_req(32'h0000_0050, 2, 1'b1, 32'hFFFF_FFFE, 1'b1);
    issue();
    wait_done(1, 20, cyc);
    load_req(32'h0000_0060, 4, 1'b0, 32'h1122_3344, 1'b1);
    issue();
    wait_done(1, 20, cyc);
    check("lw_latency", 64'(cyc), 64'd6);

    // store word, little-endian bytes, done one cycle after last byte
    store_req(32'h0000_0100, 4, 32'hDEAD_BEEF);
    issue();
    wait_done(2, 20, cyc);
    check("sw_latency", 64'(cyc), 64'd5);
    @(negedge clk);
    check("sw_ram_top_byte", 64'(ram[16'h0103]), 64'hDE);

    // simultaneous requests: store, then load, then fetch
    order_q.delete();
    store_req(32'h0000_0300, 1, 32'h0000_0077);
    load_req(32'h0000_0060, 4, 1'b0, 32'h1122_3344, 1'b1);
    fetch_req(32'h0000_0070, 32'hCAFE_BABE, 1'b1);
    issue();
    for (int i = 0; i < 60 && order_q.size() < 3; i++) @(negedge clk);
    exp_order[0] = 2; exp_order[1] = 1; exp_order[2] = 0;
    for (int i = 0; i < 3; i++)
      check("grant_order", 64'(i < order_q.size() ? order_q[i] : 99), 64'(exp_order[i]));

    // flush a 4-byte load at k = 2; the pending store starts right after
    @(negedge clk);
    load_req(32'h0000_0080, 4, 1'b0, 32'h0, 1'b0);
    issue();                                   // E0
    store_req(32'h0000_0310, 1, 32'h0000_005A);
    issue();                                   // E1
    @(posedge clk);                            // E2
    @(negedge clk);
    bus.in_rob_xbp = 1'b1;
    @(posedge clk);                            // E3, flush sampled
    @(negedge clk);
    bus.in_rob_xbp = 1'b0;
    check("flush_state_idle", 64'(dbg_state), 64'd0);
    wait_done(2, 20, cyc);
    check("flush_store_latency", 64'(cyc), 64'd3);
    repeat (8) @(negedge clk);

    // UART stall: 5 cycles without write, then one write and done
    bus.io_buffer_full = 1'b1;
    store_req(32'h0003_0000, 1, 32'h0000_00A5);
    issue();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("io_stall_no_write", 64'(bus.mem_wr), 64'd0);
    end
    bus.io_buffer_full = 1'b0;
    wait_done(2, 20, cyc);
    check("io_release_latency", 64'(cyc), 64'd2);

    // rdy low in the middle of a halfword store freezes it and gates mem_wr
    @(negedge clk);
    store_req(32'h0000_0200, 2, 32'h0000_A55A);
    issue();                                   // E0
    @(posedge clk);                            // E1, byte 0 driven
    #2 rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rdy_low_no_write", 64'(bus.mem_wr), 64'd0);
      check("rdy_low_state", 64'(dbg_state), 64'd2);
      @(posedge clk);
    end
    #2 rdy = 1'b1;
    wait_done(2, 20, cyc);
    check("rdy_resume_latency", 64'(cyc), 64'd2);

    // reset during a fetch: immediate reset values, no done pulse later
    @(negedge clk);
    fetch_req(32'h0000_0010, 32'h0, 1'b0);
    issue();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_mem_a", 64'(bus.mem_a), 64'd0);
    check("midreset_state", 64'(dbg_state), 64'd0);
    check("midreset_fetch_data", 64'(bus.out_fetcher_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // recovery after reset, address wraps nothing unusual here
    fetch_req(32'h0000_0070, 32'hCAFE_BABE, 1'b1);
    issue();
    wait_done(0, 20, cyc);
    check("post_reset_fetch_latency", 64'(cyc), 64'd6);

    repeat (4) @(negedge clk);
    check("scoreboard_empty",
          64'(exp_f_q.size() + exp_l_q.size() + exp_r_q.size() + exp_w_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
